// File: rtl/instr_fetch_unit_pkg.sv
// ============================================================================
// instr_fetch_unit_pkg: opcodes, FSM encoding, field positions. Rev 1.0
// ============================================================================
`default_nettype none

package instr_fetch_unit_pkg;

  localparam int ADDR_W_DEF = 10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_BLT   = 6'h12;
  localparam logic [5:0] OP_BGE   = 6'h13;
  localparam logic [5:0] OP_BLTU  = 6'h14;
  localparam logic [5:0] OP_BGEU  = 6'h15;
  localparam logic [5:0] OP_BLE   = 6'h16;
  localparam logic [5:0] OP_BGT   = 6'h17;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNC_MSB  = 5;
  localparam int FUNC_LSB  = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_ISSUE  = 3'd3,
    S_BRWAIT = 3'd4,
    S_HALTED = 3'd5
  } fetch_state_e;

  typedef enum logic [1:0] {
    ITYPE_R = 2'd0,
    ITYPE_I = 2'd1
  } instr_type_e;

  function automatic logic op_is_branch(input logic [5:0] op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_BLE, OP_BGT};
  endfunction

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic op_is_zext(input logic [5:0] op);
    return op inside {OP_ANDI, OP_ORI, OP_XORI};
  endfunction

  function automatic logic op_is_alu_imm(input logic [5:0] op);
    return op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI};
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// instr_fetch_unit_if: imem, issue and branch-feedback bundle. Rev 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if #(
  parameter int ADDR_W = 10
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;

  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        itype;
  logic [5:0]        opcode;
  logic [5:0]        func;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [31:0]       imm;
  logic [ADDR_W-1:0] pc;

  logic              br_valid;
  logic              br_taken;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    output instr_valid, itype, opcode, func, rs, rt, rd, shamt, imm, pc,
    input  instr_ready,
    input  br_valid, br_taken
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    input  instr_valid, itype, opcode, func, rs, rt, rd, shamt, imm, pc,
    output instr_ready,
    output br_valid, br_taken
  );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit_field_split.sv
// ============================================================================
// instr_field_split: word -> fields, imm extension and opcode class. Rev 1.0
// ============================================================================
`default_nettype none

module instr_field_split
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [5:0] HALT_OP = OP_HALT
) (
  input  logic [31:0] instr_i,
  output logic [1:0]  itype_o,
  output logic [5:0]  opcode_o,
  output logic [5:0]  func_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [31:0] imm_o,
  output logic        is_branch_o,
  output logic        is_halt_o,
  output logic        is_illegal_o
);

  logic [5:0]  opcode;
  logic [15:0] imm16;

  assign opcode = instr_i[OPC_MSB:OPC_LSB];
  assign imm16  = instr_i[IMM_MSB:IMM_LSB];

  assign opcode_o = opcode;
  assign func_o   = instr_i[FUNC_MSB:FUNC_LSB];
  assign rs_o     = instr_i[RS_MSB:RS_LSB];
  assign rt_o     = instr_i[RT_MSB:RT_LSB];
  assign rd_o     = instr_i[RD_MSB:RD_LSB];
  assign shamt_o  = instr_i[SHAMT_MSB:SHAMT_LSB];

  assign imm_o = op_is_zext(opcode) ? {16'h0000, imm16}
                                    : {{16{imm16[15]}}, imm16};

  assign itype_o = (opcode == OP_RTYPE) ? ITYPE_R : ITYPE_I;

  assign is_branch_o = op_is_branch(opcode);
  assign is_halt_o   = (opcode == HALT_OP);

  // Func is left to the decoder; only the opcode class is screened here.
  assign is_illegal_o = !((opcode == OP_RTYPE) || op_is_alu_imm(opcode) ||
                          is_branch_o || is_halt_o);

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit: PC, imem request/valid handshake and issue FSM. Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int         ADDR_W  = ADDR_W_DEF,
  parameter logic [5:0] HALT_OP = OP_HALT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_pc_i,
  output logic              halted_o,
  output logic              illegal_o,
  instr_fetch_unit_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              illegal_q, illegal_d;

  logic [1:0]        fld_itype;
  logic [5:0]        fld_opcode;
  logic [5:0]        fld_func;
  logic [4:0]        fld_rs;
  logic [4:0]        fld_rt;
  logic [4:0]        fld_rd;
  logic [4:0]        fld_shamt;
  logic [31:0]       fld_imm;
  logic              fld_is_branch;
  logic              fld_is_halt;
  logic              fld_is_illegal;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_target;

  instr_field_split #(
    .HALT_OP (HALT_OP)
  ) u_field_split (
    .instr_i      (instr_q),
    .itype_o      (fld_itype),
    .opcode_o     (fld_opcode),
    .func_o       (fld_func),
    .rs_o         (fld_rs),
    .rt_o         (fld_rt),
    .rd_o         (fld_rd),
    .shamt_o      (fld_shamt),
    .imm_o        (fld_imm),
    .is_branch_o  (fld_is_branch),
    .is_halt_o    (fld_is_halt),
    .is_illegal_o (fld_is_illegal)
  );

  // PC arithmetic is modulo 2^ADDR_W; a negative imm wraps naturally.
  assign pc_inc    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign br_target = pc_inc + fld_imm[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    illegal_d = illegal_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pc_d    = start_pc_i;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.imem_rvalid) begin
          instr_d = bus.imem_rdata;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (bus.instr_ready) begin
          if (fld_is_halt || fld_is_illegal) begin
            illegal_d = illegal_q | fld_is_illegal;
            state_d   = S_HALTED;
          end else if (fld_is_branch) begin
            state_d = S_BRWAIT;
          end else begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end
      end

      S_BRWAIT: begin
        if (bus.br_valid) begin
          pc_d    = bus.br_taken ? br_target : pc_inc;
          state_d = S_FETCH;
        end
      end

      S_HALTED: begin
        if (start_i) begin
          pc_d      = start_pc_i;
          illegal_d = 1'b0;
          state_d   = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register so reset drops them asynchronously.
  assign bus.imem_req    = (state_q == S_FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == S_ISSUE);

  assign bus.itype  = fld_itype;
  assign bus.opcode = fld_opcode;
  assign bus.func   = fld_func;
  assign bus.rs     = fld_rs;
  assign bus.rt     = fld_rt;
  assign bus.rd     = fld_rd;
  assign bus.shamt  = fld_shamt;
  assign bus.imm    = fld_imm;
  assign bus.pc     = pc_q;

  assign halted_o  = (state_q == S_HALTED);
  assign illegal_o = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit: memory responder, downstream consumer and scoreboard. Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  localparam int         AW      = 10;
  localparam logic [5:0] HALT_OP = 6'h3F;
  localparam logic [31:0] W_HALT = 32'hFC00_0000;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   word;
  } sb_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_pc;
  logic          halted;
  logic          illegal;

  instr_fetch_unit_if #(.ADDR_W(AW)) ifc ();

  instr_fetch_unit #(
    .ADDR_W  (AW),
    .HALT_OP (HALT_OP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .start_pc_i (start_pc),
    .halted_o   (halted),
    .illegal_o  (illegal),
    .bus        (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]   mem [0:(1<<AW)-1];
  sb_t           sb_q[$];
  logic [AW-1:0] fetch_q[$];

  int   n_chk  = 0;
  int   n_pass = 0;
  int   rv_delay = 0;
  int   hold_len = 0;
  logic noise    = 1'b0;
  logic sb_off   = 1'b0;
  logic br_take  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic m_branch(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    return (op == 6'h04) || (op == 6'h05) || ((op >= 6'h12) && (op <= 6'h17));
  endfunction

  function automatic logic m_zext(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    return (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
  endfunction

  function automatic logic m_illegal(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    return !((op == 6'h00) || (op == 6'h08) || (op == 6'h09) || (op == 6'h0A) ||
             m_zext(w) || m_branch(w) || (op == HALT_OP));
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] w);
    return m_zext(w) ? {16'h0000, w[15:0]} : {{16{w[15]}}, w[15:0]};
  endfunction

  // Responder, consumer and branch resolver share one negedge process.
  initial begin : p_env
    logic          rsp_pend;
    int            rsp_cnt;
    logic [AW-1:0] rsp_addr;
    logic          br_pend;
    logic          br_pend_take;
    logic          have_cur;
    int            held;
    sb_t           cur;
    logic [AW-1:0] nxt;
    logic [31:0]   imm_x;
    rsp_pend = 1'b0; rsp_cnt = 0; rsp_addr = '0;
    br_pend = 1'b0; br_pend_take = 1'b0; have_cur = 1'b0; held = 0;
    cur = '{addr: '0, word: '0};
    ifc.imem_rvalid = 1'b0; ifc.imem_rdata = '0; ifc.instr_ready = 1'b0;
    ifc.br_valid = 1'b0; ifc.br_taken = 1'b0;
    forever begin
      @(negedge clk);
      ifc.imem_rvalid = 1'b0;
      ifc.br_valid    = noise;
      ifc.br_taken    = noise;
      if (rsp_pend) begin
        if (rsp_cnt == 0) begin
          ifc.imem_rvalid = 1'b1;
          ifc.imem_rdata  = mem[rsp_addr];
          rsp_pend        = 1'b0;
          if (!sb_off) sb_q.push_back('{addr: rsp_addr, word: mem[rsp_addr]});
        end else begin
          rsp_cnt--;
        end
      end
      if (ifc.imem_req === 1'b1) begin
        chk("fetch_expected", {31'd0, fetch_q.size() > 0}, 32'd1);
        if (fetch_q.size() > 0) chk("fetch_addr", ifc.imem_addr, fetch_q.pop_front());
        rsp_pend = 1'b1; rsp_addr = ifc.imem_addr; rsp_cnt = rv_delay;
      end
      if (br_pend) begin
        ifc.br_valid = 1'b1; ifc.br_taken = br_pend_take; br_pend = 1'b0;
      end
      if (ifc.instr_valid === 1'b1) begin
        if (!have_cur) begin
          chk("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'd1);
          if (sb_q.size() > 0) cur = sb_q.pop_front();
          chk("pc",     ifc.pc,     cur.addr);
          chk("type",   ifc.itype,  (cur.word[31:26] == 6'h00) ? 32'd0 : 32'd1);
          chk("opcode", ifc.opcode, cur.word[31:26]);
          chk("func",   ifc.func,   cur.word[5:0]);
          chk("rs",     ifc.rs,     cur.word[25:21]);
          chk("rt",     ifc.rt,     cur.word[20:16]);
          chk("rd",     ifc.rd,     cur.word[15:11]);
          chk("shamt",  ifc.shamt,  cur.word[10:6]);
          chk("imm",    ifc.imm,    m_imm(cur.word));
          have_cur = 1'b1; held = 0;
        end else begin
          chk("hold_pc",    ifc.pc,       cur.addr);
          chk("hold_imm",   ifc.imm,      m_imm(cur.word));
          chk("hold_rd",    ifc.rd,       cur.word[15:11]);
          chk("hold_noreq", ifc.imem_req, 32'd0);
        end
        if (held >= hold_len) begin
          ifc.instr_ready = 1'b1;
          have_cur = 1'b0;
          nxt   = cur.addr + 1'b1;
          imm_x = m_imm(cur.word);
          if ((cur.word[31:26] == HALT_OP) || m_illegal(cur.word)) begin
            // fetch stops; no further address expected
          end else if (m_branch(cur.word)) begin
            br_pend = 1'b1; br_pend_take = br_take;
            fetch_q.push_back(br_take ? nxt + imm_x[AW-1:0] : nxt);
          end else begin
            fetch_q.push_back(nxt);
          end
        end else begin
          ifc.instr_ready = 1'b0;
          held++;
        end
      end else begin
        ifc.instr_ready = noise;
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] pc0);
    @(negedge clk);
    start_pc = pc0; start = 1'b1;
    fetch_q.push_back(pc0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_until_halt(input string tag);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_halted"}, halted, 32'd1);
    chk({tag, "_sb_empty"}, sb_q.size(), 32'd0);
    chk({tag, "_fetch_empty"}, fetch_q.size(), 32'd0);
  endtask

  initial begin : p_main
    int   lat;
    logic found;
    logic [31:0] rnd;
    logic [5:0]  legal_ops [7];
    legal_ops = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E};

    for (int i = 0; i < (1 << AW); i++) mem[i] = W_HALT;
    mem[5]    = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};  // ADD r3,r1,r2
    mem[6]    = {6'h0C, 5'd0, 5'd1, 16'h8000};            // ANDI
    mem[7]    = {6'h08, 5'd0, 5'd1, 16'h8000};            // ADDI
    mem[10]   = {6'h04, 5'd1, 5'd2, 16'hFFFD};            // BEQ -3
    mem[20]   = {6'h3E, 26'd0};                           // illegal
    mem[1023] = {6'h0D, 5'd4, 5'd5, 16'h1234};            // ORI at top of memory
    mem[2]    = {6'h05, 5'd3, 5'd4, 16'hFFFB};            // BNE -5
    mem[40]   = {6'h00, 5'd7, 5'd8, 5'd9, 5'd2, 6'h22};

    rst_n = 1'b0; start = 1'b0; start_pc = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid",   ifc.instr_valid, 32'd0);
    chk("rst_req",     ifc.imem_req,    32'd0);
    chk("rst_halted",  halted,          32'd0);
    chk("rst_illegal", illegal,         32'd0);
    chk("rst_pc",      ifc.pc,          32'd0);
    chk("rst_type",    ifc.itype,       32'd0);
    chk("rst_opcode",  ifc.opcode,      32'd0);
    chk("rst_imm",     ifc.imm,         32'd0);
    rst_n = 1'b1;

    // Program at 5 with each instruction held 4 cycles before acceptance.
    hold_len = 4;
    @(negedge clk);
    start_pc = 10'd5; start = 1'b1; fetch_q.push_back(10'd5);
    lat = 0; found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
      if (ifc.instr_valid === 1'b1) found = 1'b1;
    end
    chk("start_latency", lat, 32'd3);
    chk("add_type", ifc.itype, 32'd0);
    chk("add_func", ifc.func,  32'h20);
    chk("add_rd",   ifc.rd,    32'd3);
    @(negedge clk);
    start_pc = 10'd100; start = 1'b1;  // busy: must be ignored
    @(negedge clk);
    start = 1'b0;
    run_until_halt("prog5");
    chk("prog5_illegal", illegal, 32'd0);
    hold_len = 0;

    br_take = 1'b1;
    do_start(10'd10);
    run_until_halt("beq_taken");
    br_take = 1'b0;
    do_start(10'd10);
    run_until_halt("beq_not_taken");

    do_start(10'd20);
    run_until_halt("illegal_op");
    chk("illegal_set", illegal, 32'd1);
    do_start(10'd0);
    chk("illegal_cleared", illegal, 32'd0);
    run_until_halt("restart0");
    chk("restart0_illegal", illegal, 32'd0);

    do_start(10'd1023);
    run_until_halt("pc_wrap");
    br_take = 1'b1;
    do_start(10'd2);
    run_until_halt("bne_neg_wrap");

    // Random legal non-branch stream with slow memory and ready/br_valid noise.
    for (int i = 30; i < 36; i++) begin
      rnd = $urandom();
      mem[i] = {legal_ops[$urandom_range(0, 6)], rnd[25:0]};
    end
    rv_delay = 2; noise = 1'b1;
    do_start(10'd30);
    run_until_halt("random");
    noise = 1'b0;

    // Reset while waiting on a slow response; the late rvalid must be ignored.
    rv_delay = 3;
    do_start(10'd40);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (ifc.imem_req === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    chk("rst_wait_req_seen", found, 32'd1);
    sb_off = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", ifc.instr_valid, 32'd0);
    chk("async_req",   ifc.imem_req,    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_valid",  ifc.instr_valid, 32'd0);
      chk("post_rst_halted", halted,          32'd0);
    end
    sb_off = 1'b0; rv_delay = 0;
    do_start(10'd11);
    run_until_halt("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
